// File: rtl/piso_tx_pkg.sv
// Shared definitions for the parallel-in/serial-out transmitter:
// FSM state encoding, default word width and counter sizing helper.
package piso_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

  // Bit-counter width: ceil(log2(w)), never narrower than one bit.
  function automatic int unsigned cnt_bits(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with valid/ready intake, MSB-first
// registered serial output and a FRAME qualifier; back-to-back words without gaps.
module piso_tx
  import piso_tx_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             VALID,
  output logic             READY,
  output logic             O,
  output logic             FRAME
);

  localparam int unsigned CW = cnt_bits(WIDTH);

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [WIDTH-1:0] sr, sr_nxt;
  logic           o_nxt;
  logic           frame_nxt;
  logic           last_bit;
  logic           accept;

  // READY comes from registered state only: idle, or the cycle carrying the last bit.
  assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));
  assign READY    = (state == IDLE) || last_bit;
  assign accept   = VALID && READY;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sr_nxt    = sr;
    o_nxt     = O;
    frame_nxt = FRAME;
    if (accept) begin
      // MSB goes straight to O; the remaining bits wait in sr, left-aligned.
      state_nxt = SHIFT;
      cnt_nxt   = '0;
      sr_nxt    = {I[WIDTH-2:0], 1'b0};
      o_nxt     = I[WIDTH-1];
      frame_nxt = 1'b1;
    end else if (last_bit) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      sr_nxt    = '0;
      o_nxt     = 1'b0;
      frame_nxt = 1'b0;
    end else if (state == SHIFT) begin
      cnt_nxt   = cnt + CW'(1);
      o_nxt     = sr[WIDTH-1];
      sr_nxt    = {sr[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      O     <= 1'b0;
      FRAME <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sr    <= sr_nxt;
      O     <= o_nxt;
      FRAME <= frame_nxt;
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: a word-level model queues expected bits and
// words on each acceptance; a negedge monitor pops and compares.
module tb_piso_tx;

  localparam int unsigned W = 8;

  logic         CLK;
  logic         RESETN;
  logic [W-1:0] I;
  logic         VALID;
  logic         READY;
  logic         O;
  logic         FRAME;

  piso_tx #(.WIDTH(W)) dut (
    .CLK   (CLK),
    .RESETN(RESETN),
    .I     (I),
    .VALID (VALID),
    .READY (READY),
    .O     (O),
    .FRAME (FRAME)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Model state: bits still to appear (including the current cycle), queues of
  // expected serial bits and of whole words for the loopback receiver.
  int           remaining  = 0;
  bit           reset_seen = 0;
  bit           accepted   = 0;
  bit           bitq[$];
  logic [W-1:0] wordq[$];
  logic [W-1:0] rx = '0;
  int           nb = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    accepted = 0;
    if (!RESETN) begin
      remaining  = 0;
      bitq.delete();
      wordq.delete();
      nb         = 0;
      reset_seen = 1;
    end else if (VALID && remaining <= 1) begin
      for (int b = W - 1; b >= 0; b--) bitq.push_back(I[b]);
      wordq.push_back(I);
      remaining = W;
      accepted  = 1;
    end else if (remaining > 0) begin
      remaining--;
    end
  end

  always @(negedge CLK) begin
    if (reset_seen) begin
      cmp("READY", {31'b0, READY}, {31'b0, (remaining <= 1)});
      cmp("FRAME", {31'b0, FRAME}, {31'b0, (remaining > 0)});
      if (FRAME === 1'b1) begin
        if (bitq.size() == 0) begin
          cmp("O_unexpected_bit", 32'd1, 32'd0);
        end else begin
          cmp("O", {31'b0, O}, {31'b0, bitq.pop_front()});
        end
        rx = {rx[W-2:0], O};
        nb++;
        if (nb == W) begin
          nb = 0;
          if (wordq.size() == 0) cmp("loopback_no_word", 32'd1, 32'd0);
          else cmp("loopback", {{(32-W){1'b0}}, rx}, {{(32-W){1'b0}}, wordq.pop_front()});
        end
      end else begin
        cmp("O_idle", {31'b0, O}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Offer w and keep VALID high until the model sees it accepted (bounded).
  task automatic send_word(input logic [W-1:0] w);
    bit done;
    done  = 0;
    VALID = 1'b1;
    I     = w;
    for (int c = 0; c < 4 * W && !done; c++) begin
      tick();
      if (accepted) done = 1;
    end
    if (!done) cmp("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    VALID = 1'b0;
    for (int c = 0; c < n; c++) tick();
  endtask

  initial begin
    RESETN = 1'b0;
    VALID  = 1'b0;
    I      = '0;
    tick();
    VALID = 1'b1;   // must be ignored while in reset
    I     = 8'hEE;
    tick();
    VALID  = 1'b0;
    RESETN = 1'b1;
    idle(2);

    send_word(8'hA5);
    idle(10);
    send_word(8'h3C);
    idle(10);

    send_word(8'hFF);
    send_word(8'h00);
    idle(10);

    send_word(8'h81);
    VALID = 1'b0;
    I     = 8'h00;
    tick(); tick(); tick();
    RESETN = 1'b0;
    tick();
    RESETN = 1'b1;
    idle(2);
    send_word(8'h55);
    idle(10);

    send_word(8'hC3);
    send_word(8'h00);
    idle(10);

    for (int k = 0; k < 400; k++) begin
      VALID  = ($urandom_range(0, 3) != 0);
      I      = W'($urandom);
      RESETN = ($urandom_range(0, 79) != 0);
      tick();
    end
    RESETN = 1'b1;
    idle(2 * W + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
